wash_sequencer_param: RTL and testbench
=======================================

// Module: wash_sequencer_param
// PURPOSE
//  Parametrised washing-machine sequencer with the phase timer built in. It runs
//  fill/wash/drain, then N_RINSE rinse loops, then spin. Phase lengths scale with
//  the load size, and a tick prescaler sets the time base.
//  Adds door-open pause/resume, abort-with-drain, a done handshake and phase visibility.
// PARAMETERS
//  CNT_W     16  phase-counter width; must hold max(T_*)*4
//  TICK_DIV  1   clk cycles per timer tick (1 = every cycle)
//  T_FILL    4   fill ticks per load unit
//  T_WASH    6   agitate ticks per load unit
//  T_DRAIN   3   drain ticks (fixed, not load-scaled)
//  T_SPIN    5   spin ticks (fixed)
//  N_RINSE   1   rinse loops, 0..7
// PORTS
//  clk       in   1  rising-edge clock
//  reset     in   1  asynchronous, active-low; 0 forces reset state
//  start     in   1  level request to begin cycle; also the done acknowledge
//  door      in   1  1 = door open
//  load      in   2  load size 0..3; scale factor = load+1
//  abort     in   1  level; ends cycle via drain
//  water     out  1  fill valve
//  agitator  out  1  agitator enable
//  motor     out  1  drum motor enable
//  speed     out  1  1 = spin speed
//  pump      out  1  drain pump
//  busy      out  1  not IDLE and not DONE
//  done      out  1  cycle complete, held until start=0
//  paused    out  1  in PAUSED
//  phase     out  4  state code (below)
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE; every output 0; counters, prescaler,
//    rinse count, saved state and abort flag cleared.
//  - States/codes: IDLE 0, FILL 1, WASH 2, DRAIN 3, RFILL 4, RWASH 5, RDRAIN 6,
//    SPIN 7, DONE 8, PAUSED 9, ADRAIN 10.
//  - Output map (registered, valid the cycle after state entry):
//    FILL/RFILL: water. WASH/RWASH: agitator, motor. DRAIN/RDRAIN/ADRAIN: pump.
//    SPIN: motor, speed, pump. All other states: all actuators 0.
//  - IDLE -> FILL when start=1, door=0 and abort=0. On that edge, load is latched
//    into load_q; later load changes are ignored. Start with door=1 is ignored.
//  - Phase length: D = T_x*(load_q+1) for FILL/WASH/RFILL/RWASH; D = T_x for the
//    drain and spin phases. Each phase occupies exactly D*TICK_DIV clk cycles.
//    Counter loads D-1 on entry and decrements per tick. Exit on the tick where
//    it reads 0. Prescaler restarts on every phase entry.
//  - Order: FILL->WASH->DRAIN. If N_RINSE=0, DRAIN->SPIN. Otherwise
//    DRAIN->RFILL->RWASH->RDRAIN, repeated N_RINSE times, then SPIN.
//    SPIN->DONE.
//  - DONE: done=1. Go to IDLE on the first cycle with start=0.
//  - Door: door=1 in any busy state (FILL..SPIN, ADRAIN) -> PAUSED next cycle.
//    The current state, counter and prescaler are frozen. On door=0, return to
//    the saved state next cycle and resume with the remaining count; no restart.
//  - Abort: abort=1 in FILL..SPIN -> ADRAIN, T_DRAIN ticks, then IDLE (done
//    stays 0). Abort in ADRAIN, IDLE or DONE is ignored.
//  - Abort while PAUSED: latched; on door close, go to ADRAIN instead of the
//    saved state.
//  - Door and abort in the same cycle: enter PAUSED with the abort latched.
//  - Abort and phase expiry in the same cycle: abort wins.
//  - reset=0 mid-cycle: immediate return to IDLE with all actuators off; no
//    drain is performed.
// TESTING (defaults, TICK_DIV=1)
//  1 Full cycle, load=1, start pulse -> water 8 cyc, agit+motor 12, pump 3,
//    water 8, agit+motor 12, pump 3, motor+speed+pump 5, then done=1 held
//    until start=0.
//  2 load=3, N_RINSE=0 -> FILL 16, WASH 24, DRAIN 3, SPIN 5. Load changed
//    mid-FILL has no effect.
//  3 door=1 for 7 cycles at WASH cycle 5 -> paused=1, actuators 0, phase=9.
//    After close, WASH runs its remaining 7 cycles (load=1).
//  4 abort at SPIN cycle 2 -> phase 10, pump 3 cycles, IDLE, done never 1.
//  5 abort and door in same cycle during FILL -> PAUSED; door close ->
//    ADRAIN, not FILL.
//  6 reset low mid-RWASH -> outputs 0 immediately, phase=0. start with door=1
//    stays IDLE. TICK_DIV=3 triples every phase length.

Source files
------------

// File: rtl/wash_sequencer_param.sv
// Washing-machine sequencer with built-in load-scaled phase timer, tick prescaler,
// door pause/resume, abort-with-drain and a done handshake.
module wash_sequencer_param #(
   parameter int CNT_W    = 16,
   parameter int TICK_DIV = 1,
   parameter int T_FILL   = 4,
   parameter int T_WASH   = 6,
   parameter int T_DRAIN  = 3,
   parameter int T_SPIN   = 5,
   parameter int N_RINSE  = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       door,
   input  logic [1:0] load,
   input  logic       abort,
   output logic       water,
   output logic       agitator,
   output logic       motor,
   output logic       speed,
   output logic       pump,
   output logic       busy,
   output logic       done,
   output logic       paused,
   output logic [3:0] phase
);

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,  S_FILL  = 4'd1, S_WASH   = 4'd2, S_DRAIN = 4'd3,
      S_RFILL  = 4'd4,  S_RWASH = 4'd5, S_RDRAIN = 4'd6, S_SPIN  = 4'd7,
      S_DONE   = 4'd8,  S_PAUSED = 4'd9, S_ADRAIN = 4'd10
   } state_e;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   state_e           state_q, state_d, saved_q, saved_d, enter_st;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [2:0]       rinse_q, rinse_d;
   logic [1:0]       load_q, load_d;
   logic             abort_flag_q, abort_flag_d;
   logic             enter, tick;
   logic             water_q, water_d, agitator_q, agitator_d, motor_q, motor_d;
   logic             speed_q, speed_d, pump_q, pump_d, busy_q, busy_d;
   logic             done_q, done_d, paused_q, paused_d;
   logic [3:0]       phase_q, phase_d;

   function automatic logic [CNT_W-1:0] phase_len(input state_e s, input logic [1:0] ld);
      logic [CNT_W-1:0] scale;
      scale = CNT_W'(ld) + CNT_W'(1);
      case (s)
         S_FILL, S_RFILL:             phase_len = CNT_W'(T_FILL) * scale;
         S_WASH, S_RWASH:             phase_len = CNT_W'(T_WASH) * scale;
         S_DRAIN, S_RDRAIN, S_ADRAIN: phase_len = CNT_W'(T_DRAIN);
         S_SPIN:                      phase_len = CNT_W'(T_SPIN);
         default:                     phase_len = CNT_W'(1);
      endcase
   endfunction

   assign tick = (presc_q == PRESC_MAX);

   always_comb begin
      state_d      = state_q;
      saved_d      = saved_q;
      cnt_d        = cnt_q;
      presc_d      = presc_q;
      rinse_d      = rinse_q;
      load_d       = load_q;
      abort_flag_d = abort_flag_q;
      enter        = 1'b0;
      enter_st     = S_IDLE;
      case (state_q)
         S_IDLE: begin
            if (start && !door && !abort) begin
               load_d   = load;
               enter    = 1'b1;
               enter_st = S_FILL;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         S_PAUSED: begin
            if (abort) abort_flag_d = 1'b1;
            if (!door) begin
               abort_flag_d = 1'b0;
               // A pending abort reroutes to a fresh drain; a paused drain just resumes.
               if ((abort_flag_q || abort) && saved_q != S_ADRAIN) begin
                  enter    = 1'b1;
                  enter_st = S_ADRAIN;
               end else begin
                  state_d = saved_q;
               end
            end
         end
         default: begin
            // Priority: door freezes everything, then abort, then the phase timer.
            if (door) begin
               state_d      = S_PAUSED;
               saved_d      = state_q;
               abort_flag_d = abort && (state_q != S_ADRAIN);
            end else if (abort && state_q != S_ADRAIN) begin
               enter    = 1'b1;
               enter_st = S_ADRAIN;
            end else if (!tick) begin
               presc_d = presc_q + PW'(1);
            end else if (cnt_q != '0) begin
               cnt_d   = cnt_q - CNT_W'(1);
               presc_d = '0;
            end else begin
               enter = 1'b1;
               case (state_q)
                  S_FILL:  enter_st = S_WASH;
                  S_WASH:  enter_st = S_DRAIN;
                  S_DRAIN: begin
                     rinse_d  = '0;
                     enter_st = (N_RINSE == 0) ? S_SPIN : S_RFILL;
                  end
                  S_RFILL: enter_st = S_RWASH;
                  S_RWASH: enter_st = S_RDRAIN;
                  S_RDRAIN: begin
                     if (int'(rinse_q) + 1 >= N_RINSE) begin
                        enter_st = S_SPIN;
                     end else begin
                        enter_st = S_RFILL;
                        rinse_d  = rinse_q + 3'd1;
                     end
                  end
                  S_SPIN:  enter_st = S_DONE;
                  default: enter_st = S_IDLE;
               endcase
            end
         end
      endcase
      if (enter) begin
         state_d = enter_st;
         cnt_d   = phase_len(enter_st, load_d) - CNT_W'(1);
         presc_d = '0;
      end
   end

   // Outputs decode the next state so they line up with the state register.
   always_comb begin
      water_d    = (state_d == S_FILL) || (state_d == S_RFILL);
      agitator_d = (state_d == S_WASH) || (state_d == S_RWASH);
      motor_d    = agitator_d || (state_d == S_SPIN);
      speed_d    = (state_d == S_SPIN);
      pump_d     = (state_d == S_DRAIN) || (state_d == S_RDRAIN) ||
                   (state_d == S_ADRAIN) || (state_d == S_SPIN);
      busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d     = (state_d == S_DONE);
      paused_d   = (state_d == S_PAUSED);
      phase_d    = state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         saved_q      <= S_IDLE;
         cnt_q        <= '0;
         presc_q      <= '0;
         rinse_q      <= '0;
         load_q       <= '0;
         abort_flag_q <= 1'b0;
         water_q      <= 1'b0;
         agitator_q   <= 1'b0;
         motor_q      <= 1'b0;
         speed_q      <= 1'b0;
         pump_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         paused_q     <= 1'b0;
         phase_q      <= '0;
      end else begin
         state_q      <= state_d;
         saved_q      <= saved_d;
         cnt_q        <= cnt_d;
         presc_q      <= presc_d;
         rinse_q      <= rinse_d;
         load_q       <= load_d;
         abort_flag_q <= abort_flag_d;
         water_q      <= water_d;
         agitator_q   <= agitator_d;
         motor_q      <= motor_d;
         speed_q      <= speed_d;
         pump_q       <= pump_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         paused_q     <= paused_d;
         phase_q      <= phase_d;
      end
   end

   assign water    = water_q;
   assign agitator = agitator_q;
   assign motor    = motor_q;
   assign speed    = speed_q;
   assign pump     = pump_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign paused   = paused_q;
   assign phase    = phase_q;

endmodule

// File: tb/tb_wash_sequencer_param.sv
// Directed bench: three sequencer instances (defaults, no rinse, tick divide by 3).
module tb_wash_sequencer_param;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start [3];
   logic       door  [3];
   logic       abort [3];
   logic [1:0] load  [3];
   logic       water [3], agit [3], motor [3], speed [3], pump [3];
   logic       busy [3], done [3], paused [3];
   logic [3:0] phase [3];
   int         n_chk = 0;
   int         n_fail = 0;
   logic       done_seen0 = 1'b0;

   always #5 clk = ~clk;

   wash_sequencer_param u0 (
      .clk(clk), .reset(rst_n), .start(start[0]), .door(door[0]), .load(load[0]),
      .abort(abort[0]), .water(water[0]), .agitator(agit[0]), .motor(motor[0]),
      .speed(speed[0]), .pump(pump[0]), .busy(busy[0]), .done(done[0]),
      .paused(paused[0]), .phase(phase[0]));

   wash_sequencer_param #(.N_RINSE(0)) u1 (
      .clk(clk), .reset(rst_n), .start(start[1]), .door(door[1]), .load(load[1]),
      .abort(abort[1]), .water(water[1]), .agitator(agit[1]), .motor(motor[1]),
      .speed(speed[1]), .pump(pump[1]), .busy(busy[1]), .done(done[1]),
      .paused(paused[1]), .phase(phase[1]));

   wash_sequencer_param #(.TICK_DIV(3)) u2 (
      .clk(clk), .reset(rst_n), .start(start[2]), .door(door[2]), .load(load[2]),
      .abort(abort[2]), .water(water[2]), .agitator(agit[2]), .motor(motor[2]),
      .speed(speed[2]), .pump(pump[2]), .busy(busy[2]), .done(done[2]),
      .paused(paused[2]), .phase(phase[2]));

   always @(negedge clk) if (done[0] === 1'b1) done_seen0 = 1'b1;

   // Counts consecutive cycles spent in one phase code; actuators sampled on the first.
   task automatic count_phase(input int d, input logic [3:0] code, output int n,
                              output logic [4:0] act);
      n   = 0;
      act = {water[d], agit[d], motor[d], speed[d], pump[d]};
      while (phase[d] === code && n < 300) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start[d] = 1'b0; door[d] = 1'b0; abort[d] = 1'b0; load[d] = 2'd0;
      end
      #3;
      for (int d = 0; d < 3; d++) begin
         n_chk++;
         if ({water[d], agit[d], motor[d], speed[d], pump[d], busy[d], done[d],
              paused[d], phase[d]} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d phase=%0d busy=%b expected all zero",
                     d, phase[d], busy[d]);
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_cycle();
      int         codes [7] = '{1, 2, 3, 4, 5, 6, 7};
      int         lens  [7] = '{8, 12, 3, 8, 12, 3, 5};
      logic [4:0] acts  [7] = '{5'b10000, 5'b01100, 5'b00001, 5'b10000, 5'b01100,
                                5'b00001, 5'b00111};
      int         n;
      logic [4:0] act;
      start[0] = 1'b1; load[0] = 2'd1;
      @(negedge clk);
      n_chk++;
      if (busy[0] !== 1'b1) begin
         n_fail++; $display("FAIL full_busy got=%b expected=1", busy[0]);
      end
      for (int i = 0; i < 7; i++) begin
         count_phase(0, 4'(codes[i]), n, act);
         n_chk++;
         if (n !== lens[i] || act !== acts[i]) begin
            n_fail++;
            $display("FAIL full_phase%0d len=%0d act=%b expected len=%0d act=%b",
                     codes[i], n, act, lens[i], acts[i]);
         end
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd8 || done[0] !== 1'b1 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL full_done_hold phase=%0d done=%b busy=%b expected 8 1 0",
                  phase[0], done[0], busy[0]);
      end
      start[0] = 1'b0;
      @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd0 || done[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL full_ack phase=%0d done=%b expected 0 0", phase[0], done[0]);
      end
   endtask

   task automatic test_load_scaling();
      int         codes [4] = '{1, 2, 3, 7};
      int         lens  [4] = '{16, 24, 3, 5};
      int         n;
      logic [4:0] act;
      start[1] = 1'b1; load[1] = 2'd3;
      @(negedge clk);
      load[1] = 2'd0;
      for (int i = 0; i < 4; i++) begin
         count_phase(1, 4'(codes[i]), n, act);
         n_chk++;
         if (n !== lens[i]) begin
            n_fail++;
            $display("FAIL load3_phase%0d len=%0d expected=%0d", codes[i], n, lens[i]);
         end
      end
      n_chk++;
      if (done[1] !== 1'b1) begin
         n_fail++; $display("FAIL load3_done got=%b expected=1", done[1]);
      end
      start[1] = 1'b0;
      @(negedge clk);
   endtask

   // Leaves u0 at the first SPIN cycle for test_abort_spin.
   task automatic test_pause();
      int         n;
      logic [4:0] act;
      start[0] = 1'b1; load[0] = 2'd1;
      @(negedge clk);
      count_phase(0, 4'd1, n, act);
      repeat (5) @(negedge clk);
      door[0] = 1'b1;
      @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd9 || paused[0] !== 1'b1 ||
          {water[0], agit[0], motor[0], speed[0], pump[0]} !== 5'd0) begin
         n_fail++;
         $display("FAIL pause_enter phase=%0d paused=%b agit=%b expected 9 1 0",
                  phase[0], paused[0], agit[0]);
      end
      repeat (6) @(negedge clk);
      door[0] = 1'b0;
      @(negedge clk);
      count_phase(0, 4'd2, n, act);
      n_chk++;
      if (n !== 7 || act !== 5'b01100) begin
         n_fail++;
         $display("FAIL pause_resume len=%0d act=%b expected len=7 act=01100", n, act);
      end
      count_phase(0, 4'd3, n, act);
      count_phase(0, 4'd4, n, act);
      count_phase(0, 4'd5, n, act);
      count_phase(0, 4'd6, n, act);
   endtask

   task automatic test_abort_spin();
      int         n;
      logic [4:0] act;
      done_seen0 = 1'b0;
      n_chk++;
      if (phase[0] !== 4'd7) begin
         n_fail++; $display("FAIL abort_spin_pre phase=%0d expected=7", phase[0]);
      end
      repeat (2) @(negedge clk);
      abort[0] = 1'b1; start[0] = 1'b0;
      @(negedge clk);
      abort[0] = 1'b0;
      count_phase(0, 4'd10, n, act);
      n_chk++;
      if (n !== 3 || act !== 5'b00001) begin
         n_fail++;
         $display("FAIL abort_spin_drain len=%0d act=%b expected len=3 act=00001", n, act);
      end
      @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd0 || done_seen0 !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_spin_end phase=%0d done_seen=%b busy=%b expected 0 0 0",
                  phase[0], done_seen0, busy[0]);
      end
   endtask

   task automatic test_abort_door();
      int         n;
      logic [4:0] act;
      start[0] = 1'b1; load[0] = 2'd0;
      @(negedge clk);
      repeat (2) @(negedge clk);
      door[0] = 1'b1; abort[0] = 1'b1; start[0] = 1'b0;
      @(negedge clk);
      abort[0] = 1'b0;
      n_chk++;
      if (phase[0] !== 4'd9) begin
         n_fail++; $display("FAIL abort_door_pause phase=%0d expected=9", phase[0]);
      end
      repeat (2) @(negedge clk);
      door[0] = 1'b0;
      @(negedge clk);
      count_phase(0, 4'd10, n, act);
      n_chk++;
      if (n !== 3) begin
         n_fail++; $display("FAIL abort_door_drain len=%0d expected=3", n);
      end
      n_chk++;
      if (phase[0] !== 4'd0) begin
         n_fail++; $display("FAIL abort_door_idle phase=%0d expected=0", phase[0]);
      end
   endtask

   task automatic test_reset_mid();
      int         n;
      logic [4:0] act;
      start[0] = 1'b1; load[0] = 2'd0;
      @(negedge clk);
      count_phase(0, 4'd1, n, act);
      count_phase(0, 4'd2, n, act);
      count_phase(0, 4'd3, n, act);
      count_phase(0, 4'd4, n, act);
      @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd5 || agit[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_pre phase=%0d agit=%b expected 5 1", phase[0], agit[0]);
      end
      start[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({water[0], agit[0], motor[0], speed[0], pump[0]} !== 5'd0 || phase[0] !== 4'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async phase=%0d agit=%b motor=%b expected 0 0 0",
                  phase[0], agit[0], motor[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd0 || pump[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_nodrain phase=%0d pump=%b expected 0 0", phase[0], pump[0]);
      end
   endtask

   task automatic test_door_start();
      door[0] = 1'b1; start[0] = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if (phase[0] !== 4'd0 || busy[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL door_start phase=%0d busy=%b expected 0 0", phase[0], busy[0]);
      end
      door[0] = 1'b0; start[0] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tick_div();
      int         lens [7] = '{12, 18, 9, 12, 18, 9, 15};
      int         n;
      logic [4:0] act;
      start[2] = 1'b1; load[2] = 2'd0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         count_phase(2, 4'(i + 1), n, act);
         n_chk++;
         if (n !== lens[i]) begin
            n_fail++;
            $display("FAIL tickdiv_phase%0d len=%0d expected=%0d", i + 1, n, lens[i]);
         end
      end
      n_chk++;
      if (done[2] !== 1'b1) begin
         n_fail++; $display("FAIL tickdiv_done got=%b expected=1", done[2]);
      end
      start[2] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_load_scaling();
      test_pause();
      test_abort_spin();
      test_abort_door();
      test_reset_mid();
      test_door_start();
      test_tick_div();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
